fft_uart_tx_serializer: RTL

FFT_UART_TX_SERIALIZER -- requirements
Module: fft_uart_tx_serializer

---
 rtl/fft_uart_tx_serializer_pkg.sv | 28 ++
 rtl/fft_uart_tx_serializer_if.sv | 21 ++
 rtl/fft_uart_tx_serializer_byte_tx.sv | 151 +++++++++++++++
 rtl/fft_uart_tx_serializer.sv | 112 +++++++++++
 4 files changed

// File: rtl/fft_uart_tx_serializer_pkg.sv
// Shared definitions for the FFT result UART serializer: state encoding,
// UART frame levels and word/byte sizing helpers.
package fft_out_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    START   = 3'd2,
    DATA    = 3'd3,
    PARITY  = 3'd4,
    STOP    = 3'd5,
    ACK     = 3'd6
  } state_t;

  localparam logic START_LEVEL   = 1'b0;
  localparam logic STOP_LEVEL    = 1'b1;
  localparam logic IDLE_LEVEL    = 1'b1;
  localparam int   BITS_PER_BYTE = 8;

  function automatic int bytes_per_word(input int word_w);
    return word_w / 8;
  endfunction

  function automatic logic even_parity(input logic [7:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/fft_uart_tx_serializer_if.sv
// Read-strobe / result-data / UART-line bundle between the FFT output
// address generator and the serializer.
interface fft_uart_tx_serializer_if #(
  parameter int WORD_W = 32
) ();
  logic              en_rd;
  logic [WORD_W-1:0] rd_data;
  logic              tx;
  logic              en_out;
  logic              busy;

  modport master (
    output en_rd, rd_data,
    input  tx, en_out, busy
  );

  modport slave (
    input  en_rd, rd_data,
    output tx, en_out, busy
  );
endinterface

// File: rtl/fft_uart_tx_serializer_byte_tx.sv
// Single-byte UART transmitter: start, 8 data bits LSB first, optional even
// parity (FFT_UART_PARITY_EN) and stop, each held t_1_bit cycles.
module uart_byte_tx
  import fft_out_pkg::*;
#(
  parameter int t_1_bit = 5207
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       done
);

  localparam int             TMR_W    = (t_1_bit > 1) ? $clog2(t_1_bit) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(t_1_bit - 1);
  localparam logic [2:0]     BIT_LAST = 3'(BITS_PER_BYTE - 1);

  state_t           phase_r, phase_s;
  logic [TMR_W-1:0] timer_r, timer_s;
  logic [2:0]       bit_r, bit_s;
  logic [7:0]       shift_r, shift_s;
  logic             tx_r, tx_s;
  logic             tick_s;
`ifdef FFT_UART_PARITY_EN
  logic             par_r, par_s;
`endif

  assign tick_s = (timer_r == TMR_LAST);
  // done is combinational so the top can chain the next start bit with no gap
  assign done   = (phase_r == STOP) && tick_s;
  assign tx     = tx_r;

  // Bit-level sequencing; tx_s is the level the line takes after this edge
  always_comb begin
    phase_s = phase_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    tx_s    = tx_r;
`ifdef FFT_UART_PARITY_EN
    par_s   = par_r;
`endif
    if (phase_r == IDLE || tick_s) begin
      timer_s = '0;
    end else begin
      timer_s = timer_r + TMR_W'(1'b1);
    end
    case (phase_r)
      IDLE: begin
        if (start) begin
          phase_s = START;
          tx_s    = START_LEVEL;
          shift_s = byte_in;
          bit_s   = 3'd0;
`ifdef FFT_UART_PARITY_EN
          par_s   = even_parity(byte_in);
`endif
        end else begin
          tx_s = IDLE_LEVEL;
        end
      end
      START: begin
        if (tick_s) begin
          phase_s = DATA;
          tx_s    = shift_r[0];
        end else begin
          tx_s = START_LEVEL;
        end
      end
      DATA: begin
        if (tick_s) begin
          if (bit_r == BIT_LAST) begin
            bit_s   = 3'd0;
`ifdef FFT_UART_PARITY_EN
            phase_s = PARITY;
            tx_s    = par_r;
`else
            phase_s = STOP;
            tx_s    = STOP_LEVEL;
`endif
          end else begin
            bit_s   = bit_r + 3'd1;
            shift_s = {1'b0, shift_r[7:1]};
            tx_s    = shift_r[1];
          end
        end else begin
          tx_s = tx_r;
        end
      end
`ifdef FFT_UART_PARITY_EN
      PARITY: begin
        if (tick_s) begin
          phase_s = STOP;
          tx_s    = STOP_LEVEL;
        end else begin
          tx_s = tx_r;
        end
      end
`endif
      STOP: begin
        if (tick_s) begin
          if (start) begin
            phase_s = START;
            tx_s    = START_LEVEL;
            shift_s = byte_in;
            bit_s   = 3'd0;
`ifdef FFT_UART_PARITY_EN
            par_s   = even_parity(byte_in);
`endif
          end else begin
            phase_s = IDLE;
            tx_s    = IDLE_LEVEL;
          end
        end else begin
          tx_s = STOP_LEVEL;
        end
      end
      default: begin
        phase_s = IDLE;
        tx_s    = IDLE_LEVEL;
        bit_s   = 3'd0;
        shift_s = 8'h00;
      end
    endcase
  end

  // Byte transmitter state and registered line driver
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= IDLE;
      timer_r <= '0;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      tx_r    <= IDLE_LEVEL;
`ifdef FFT_UART_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      phase_r <= phase_s;
      timer_r <= timer_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
`ifdef FFT_UART_PARITY_EN
      par_r   <= par_s;
`endif
    end
  end

endmodule

// File: rtl/fft_uart_tx_serializer.sv
// Captures one FFT result word per read strobe and ships it LSB byte first
// over UART, then pulses en_out. Parity bit enabled by FFT_UART_PARITY_EN.
module fft_uart_tx_serializer
  import fft_out_pkg::*;
#(
  parameter int t_1_bit = 5207,
  parameter int WORD_W  = 32
) (
  input logic                     clk,
  input logic                     rst_n,
  fft_uart_tx_serializer_if.slave bus
);

  localparam int               BYTES     = bytes_per_word(WORD_W);
  localparam int               CNT_W     = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(BYTES - 1);

  // START spans the whole multi-byte transmission here; the bit-level
  // phases (START/DATA/PARITY/STOP) are tracked inside uart_byte_tx.
  state_t            state_r, state_s;
  logic [WORD_W-1:0] shift_r, shift_s, shifted_s;
  logic [CNT_W-1:0]  byte_cnt_r, byte_cnt_s;
  logic              start_s;
  logic [7:0]        byte_s;
  logic              byte_done_s;
  logic              byte_tx_s;
  logic              en_out_r;
  logic              busy_r;

  assign shifted_s = shift_r >> 4'd8;

  // Word-level sequencing and byte hand-off
  always_comb begin
    state_s    = state_r;
    shift_s    = shift_r;
    byte_cnt_s = byte_cnt_r;
    start_s    = 1'b0;
    byte_s     = shifted_s[7:0];
    case (state_r)
      IDLE: begin
        if (bus.en_rd) begin
          state_s = CAPTURE;
        end else begin
          state_s = IDLE;
        end
      end
      CAPTURE: begin
        start_s    = 1'b1;
        byte_s     = bus.rd_data[7:0];
        shift_s    = bus.rd_data;
        byte_cnt_s = '0;
        state_s    = START;
      end
      START: begin
        if (byte_done_s) begin
          if (byte_cnt_r == BYTE_LAST) begin
            state_s    = ACK;
            byte_cnt_s = '0;
            shift_s    = '0;
          end else begin
            start_s    = 1'b1;
            byte_cnt_s = byte_cnt_r + CNT_W'(1'b1);
            shift_s    = shifted_s;
          end
        end else begin
          state_s = START;
        end
      end
      ACK: begin
        state_s = IDLE;
      end
      default: begin
        state_s    = IDLE;
        shift_s    = '0;
        byte_cnt_s = '0;
      end
    endcase
  end

  // Word state, shift register and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      shift_r    <= '0;
      byte_cnt_r <= '0;
      en_out_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      shift_r    <= shift_s;
      byte_cnt_r <= byte_cnt_s;
      en_out_r   <= (state_s == ACK);
      busy_r     <= (state_s != IDLE);
    end
  end

  uart_byte_tx #(
    .t_1_bit (t_1_bit)
  ) u_byte_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_s),
    .byte_in (byte_s),
    .tx      (byte_tx_s),
    .done    (byte_done_s)
  );

  assign bus.tx     = byte_tx_s;
  assign bus.en_out = en_out_r;
  assign bus.busy   = busy_r;

endmodule
